tc0480scp_rom_responder: RTL

Graphics-ROM responder for the TC0480SCP background tile fetcher. It services the toggle req/ack protocol (`rom_req`/`rom_ack`, 23-bit byte address, 64-bit line) by issuing one four-beat 16-bit read burst to the SDRAM/DDR arbiter port and assembling the beats into a 64-bit line. A single-entry line cache answers a repeated address in one clock without a memory access. It sits between the tilemap core and the board memory arbiter.

---
 rtl/tc0480scp_rom_responder_if.sv | 26 ++
 rtl/tc0480scp_rom_responder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/tc0480scp_rom_responder_if.sv
// Tile-fetcher ROM port (toggle req/ack, 64-bit line) plus the burst-read arbiter port.
// slave is the responder side; master is the client/arbiter side.
interface tc0480scp_rom_responder_if #(
  parameter int MEM_AW = 25
);
  logic [22:0]       rom_address;
  logic              rom_req;
  logic [63:0]       rom_data;
  logic              rom_ack;
  logic              flush;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [15:0]       mem_data;
  logic              mem_valid;

  modport slave (
    input  rom_address, rom_req, flush, mem_ready, mem_data, mem_valid,
    output rom_data, rom_ack, mem_addr, mem_rd
  );

  modport master (
    output rom_address, rom_req, flush, mem_ready, mem_data, mem_valid,
    input  rom_data, rom_ack, mem_addr, mem_rd
  );
endinterface

// File: rtl/tc0480scp_rom_responder.sv
// TC0480SCP ROM responder: line-cache hit acks in 1 clk, miss fetches one 4x16 burst (ack on 4th beat).
// mem_rd/mem_addr held until mem_ready; one request in flight, rom_data held until the ack edge.
module tc0480scp_rom_responder #(
  parameter int unsigned ROM_BASE = 0,
  parameter int          MEM_AW   = 25
) (
  input  logic                       clk,
  input  logic                       reset_n,
  tc0480scp_rom_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BEAT} state_t;

  state_t            state_q, state_d;
  logic [19:0]       tag_q, tag_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [47:0]       asm_q, asm_d;
  logic [63:0]       rom_data_q, rom_data_d;
  logic              rom_ack_q, rom_ack_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              cache_vld_q, cache_vld_d;
  logic [19:0]       cache_tag_q, cache_tag_d;
  logic [63:0]       cache_line_q, cache_line_d;

  logic [31:0]       base_sum;
  logic              unused_bits;

  // Word address of the line: tag * 4 words, offset by the ROM region base.
  assign base_sum    = ROM_BASE + {10'd0, bus.rom_address[22:3], 2'b00};
  assign unused_bits = ^{bus.rom_address[2:0], base_sum};

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    rom_data_d   = rom_data_q;
    rom_ack_d    = rom_ack_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = mem_rd_q;
    cache_vld_d  = cache_vld_q & ~bus.flush;
    cache_tag_d  = cache_tag_q;
    cache_line_d = cache_line_q;

    case (state_q)
      IDLE: begin
        if (bus.rom_req != rom_ack_q) begin
          tag_d = bus.rom_address[22:3];
          if (cache_vld_q && !bus.flush && (cache_tag_q == bus.rom_address[22:3])) begin
            rom_data_d = cache_line_q;
            rom_ack_d  = bus.rom_req;
          end else begin
            mem_addr_d = base_sum[MEM_AW-1:0];
            mem_rd_d   = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_rd_q && bus.mem_ready) begin
          mem_rd_d = 1'b0;
          cnt_d    = 2'd0;
          state_d  = BEAT;
        end
      end
      BEAT: begin
        if (bus.mem_valid) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: asm_d[15:0]  = bus.mem_data;
            2'd1: asm_d[31:16] = bus.mem_data;
            2'd2: asm_d[47:32] = bus.mem_data;
            default: begin
              // Fill sets valid after the flush clear above, so a coincident flush loses.
              rom_data_d   = {bus.mem_data, asm_q};
              cache_line_d = {bus.mem_data, asm_q};
              cache_tag_d  = tag_q;
              cache_vld_d  = 1'b1;
              rom_ack_d    = bus.rom_req;
              state_d      = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      cnt_q        <= '0;
      asm_q        <= '0;
      rom_data_q   <= '0;
      rom_ack_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      cache_vld_q  <= 1'b0;
      cache_tag_q  <= '0;
      cache_line_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      rom_data_q   <= rom_data_d;
      rom_ack_q    <= rom_ack_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      cache_vld_q  <= cache_vld_d;
      cache_tag_q  <= cache_tag_d;
      cache_line_q <= cache_line_d;
    end
  end

  assign bus.rom_data = rom_data_q;
  assign bus.rom_ack  = rom_ack_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;

endmodule
